// File: rtl/noc_pkg.sv
// Types and constants shared by the NoC arbiter and the NoC model.
package noc_pkg;

    localparam int DATA_W     = 64;
    localparam int MAX_CPU_NB = 16;
    localparam int CPU_IDX_W  = 4;

    typedef logic [CPU_IDX_W-1:0] cpu_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    // Round-robin successor of idx among nb ports.
    function automatic cpu_idx_t wrap_inc(input cpu_idx_t idx, input int nb);
        return (int'(idx) == nb - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// CPU request ports and the shared NoC output channel of the round-robin arbiter.
interface noc_rr_arbiter_if
    import noc_pkg::*;
#(
    parameter int CPU_NB = 4
) ();

    localparam int SRC_W = $clog2(CPU_NB);

    logic [CPU_NB-1:0] req_vld;
    data_t             req_data [CPU_NB];
    logic [CPU_NB-1:0] req_rdy;
    logic              out_vld;
    data_t             out_data;
    logic [SRC_W-1:0]  out_src;
    logic              out_rdy;
    logic [CPU_NB-1:0] cpu_done;
    logic              all_done;

    modport slave (
        input  req_vld, req_data, out_rdy,
        output req_rdy, out_vld, out_data, out_src, cpu_done, all_done
    );

    modport master (
        output req_vld, req_data, out_rdy,
        input  req_rdy, out_vld, out_data, out_src, cpu_done, all_done
    );

endinterface

// File: rtl/noc_rr_pick.sv
// Combinational round-robin pick: first eligible index at or above rr_ptr, wrapping.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int CPU_NB = 4
) (
    input  logic [CPU_NB-1:0] eligible,
    input  cpu_idx_t          rr_ptr,
    output logic              grant_vld,
    output cpu_idx_t          grant_idx
);

    logic [MAX_CPU_NB-1:0] elig_pad;
    logic [CPU_IDX_W:0]    pos;

    always_comb begin
        elig_pad               = '0;
        elig_pad[CPU_NB-1:0]   = eligible;
        grant_vld              = 1'b0;
        grant_idx              = '0;
        pos                    = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = CPU_NB - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (CPU_IDX_W + 1)'(k);
            if (pos >= (CPU_IDX_W + 1)'(CPU_NB))
                pos = pos - (CPU_IDX_W + 1)'(CPU_NB);
            if (elig_pad[pos[CPU_IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = pos[CPU_IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter of CPU_NB CPU ports onto one registered NoC channel,
// retiring each CPU after TRANSACTION_NB accepted transactions.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int CPU_NB         = 4,
    parameter int TRANSACTION_NB = 1000
) (
    input  logic              clk,
    input  logic              rst,
    noc_rr_arbiter_if.slave   bus
);

    localparam int SRC_W = $clog2(CPU_NB);

    logic              out_vld_q,  out_vld_d;
    data_t             out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q,  out_src_d;
    cpu_idx_t          rr_ptr_q,   rr_ptr_d;
    logic [31:0]       cnt_q [CPU_NB];
    logic [31:0]       cnt_d [CPU_NB];
    logic [CPU_NB-1:0] cpu_done_q, cpu_done_d;

    logic [CPU_NB-1:0] eligible;
    logic [CPU_NB-1:0] req_rdy;
    logic              can_accept;
    logic              accept;
    logic              grant_vld;
    cpu_idx_t          grant_idx;

    assign eligible   = bus.req_vld & ~cpu_done_q;
    assign can_accept = !out_vld_q || bus.out_rdy;
    assign accept     = can_accept && grant_vld && !rst;

    noc_rr_pick #(.CPU_NB(CPU_NB)) u_pick (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always_comb begin
        req_rdy    = '0;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        cpu_done_d = cpu_done_q;
        for (int i = 0; i < CPU_NB; i++) cnt_d[i] = cnt_q[i];

        // Stage boundary: a grant reloads the output register, else a pop empties it.
        if (accept) begin
            out_vld_d = 1'b1;
            out_src_d = grant_idx[SRC_W-1:0];
            rr_ptr_d  = wrap_inc(grant_idx, CPU_NB);
            for (int i = 0; i < CPU_NB; i++) begin
                if (grant_idx == cpu_idx_t'(i)) begin
                    req_rdy[i] = 1'b1;
                    out_data_d = bus.req_data[i];
                end
            end
        end else if (bus.out_rdy) begin
            out_vld_d = 1'b0;
        end

        // Grants only go to non-done CPUs, so counters saturate at TRANSACTION_NB.
        for (int i = 0; i < CPU_NB; i++) begin
            if (req_rdy[i]) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
                if (cnt_d[i] == 32'(TRANSACTION_NB)) cpu_done_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            rr_ptr_q   <= '0;
            cpu_done_q <= '0;
            for (int i = 0; i < CPU_NB; i++) cnt_q[i] <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
            cpu_done_q <= cpu_done_d;
            for (int i = 0; i < CPU_NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.req_rdy  = req_rdy;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.out_src  = out_src_q;
    assign bus.cpu_done = cpu_done_q;
    assign bus.all_done = (&cpu_done_q) && !out_vld_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Scoreboard bench for noc_rr_arbiter (CPU_NB=4, TRANSACTION_NB=3).
module tb_noc_rr_arbiter;
    import noc_pkg::*;

    localparam int NB = 4;
    localparam int TN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_rr_arbiter_if #(.CPU_NB(NB)) bus ();

    noc_rr_arbiter #(.CPU_NB(NB), .TRANSACTION_NB(TN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          src;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          src_log[$];
    logic [63:0] data_log[$];
    int          pop_cyc[$];

    bit          chk_en = 1'b0;
    int          cyc    = 0;
    bit          m_vld  = 1'b0;
    int          m_ptr  = 0;
    int          m_cnt [NB];
    bit [NB-1:0] m_done = '0;
    int          obs_acc1 = 0;

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [NB-1:0] exp_rdy;
        bit            can;
        int            g;
        int            idx;
        cyc++;
        if (chk_en) begin
            exp_rdy = '0;
            g       = -1;
            check_eq("out_vld", bus.out_vld, m_vld);
            check_eq("cpu_done", bus.cpu_done, m_done);
            check_eq("all_done", bus.all_done, (&m_done) && !m_vld);
            if (m_vld) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    check_eq("out_src", bus.out_src, sb[0].src);
                    check_eq("out_data", bus.out_data, sb[0].data);
                end
            end
            can = !m_vld || bus.out_rdy;
            if (!rst && can) begin
                for (int k = 0; k < NB; k++) begin
                    idx = (m_ptr + k) % NB;
                    if (g < 0 && bus.req_vld[idx] && !m_done[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("req_rdy", bus.req_rdy, exp_rdy);
            if (bus.req_vld[1] && bus.req_rdy[1]) obs_acc1++;

            if (rst) begin
                m_vld  = 1'b0;
                m_ptr  = 0;
                m_done = '0;
                for (int i = 0; i < NB; i++) m_cnt[i] = 0;
                sb.delete();
            end else begin
                if (m_vld && bus.out_rdy) begin
                    src_log.push_back(int'(bus.out_src));
                    data_log.push_back(bus.out_data);
                    pop_cyc.push_back(cyc);
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_vld = 1'b0;
                end
                if (g >= 0) begin
                    sb.push_back('{src: g, data: bus.req_data[g]});
                    m_vld = 1'b1;
                    m_ptr = (g + 1) % NB;
                    m_cnt[g]++;
                    if (m_cnt[g] == TN) m_done[g] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        src_log.delete();
        data_log.delete();
        pop_cyc.delete();
    endtask

    initial begin
        for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        rst         = 1'b1;
        bus.req_vld = '0;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < NB; i++) bus.req_data[i] = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check_eq("rst_out_vld", bus.out_vld, 0);
        check_eq("rst_cpu_done", bus.cpu_done, 0);
        check_eq("rst_req_rdy", bus.req_rdy, 0);
        rst = 1'b0;

        // All four CPUs requesting with a free-flowing channel.
        clear_logs();
        bus.out_rdy = 1'b1;
        for (int i = 0; i < NB; i++) bus.req_data[i] = 64'h1000 + 64'(i);
        bus.req_vld = '1;
        for (int c = 0; c < 40 && !bus.all_done; c++) tick();
        check_eq("t1_all_done", bus.all_done, 1);
        check_eq("t1_pops", src_log.size(), 12);
        for (int c = 0; c < src_log.size(); c++) begin
            check_eq("t1_src_seq", src_log[c], c % NB);
            check_eq("t1_back_to_back", pop_cyc[c] - pop_cyc[0], c);
        end
        bus.req_vld = '0;

        // Single requester at full throughput.
        do_reset();
        clear_logs();
        for (int c = 0; c < 8; c++) begin
            bus.req_vld     = 4'b0100;
            bus.req_data[2] = 64'hA5A5_0000_0000_0000 + 64'(m_cnt[2] + 1);
            tick();
        end
        bus.req_vld = '0;
        check_eq("t2_pops", src_log.size(), 3);
        for (int c = 0; c < data_log.size(); c++) begin
            check_eq("t2_data", data_log[c], 64'hA5A5_0000_0000_0000 + 64'(c + 1));
            check_eq("t2_back_to_back", pop_cyc[c] - pop_cyc[0], c);
        end
        check_eq("t2_cpu_done", bus.cpu_done, 4'b0100);

        // Backpressure: one acceptance then a stall, then pop and grant together.
        do_reset();
        clear_logs();
        obs_acc1        = 0;
        bus.out_rdy     = 1'b0;
        bus.req_vld     = 4'b0010;
        bus.req_data[1] = 64'hDEAD_0001;
        tick();
        bus.req_data[1] = 64'hDEAD_0002;
        for (int c = 0; c < 5; c++) begin
            check_eq("t3_stall_rdy", bus.req_rdy[1], 0);
            check_eq("t3_stall_data", bus.out_data, 64'hDEAD_0001);
            tick();
        end
        check_eq("t3_one_accept", obs_acc1, 1);
        bus.out_rdy = 1'b1;
        #1;
        check_eq("t3_grant_on_pop", bus.req_rdy, 4'b0010);
        tick();
        check_eq("t3_no_bubble", bus.out_vld, 1);
        check_eq("t3_next_data", bus.out_data, 64'hDEAD_0002);
        bus.req_vld = '0;
        tick();
        tick();

        // Pointer at 3: CPU3 wins before CPU0 wraps in.
        do_reset();
        clear_logs();
        bus.req_vld = 4'b0100;
        tick();
        check_eq("t4_ptr", dut.rr_ptr_q, 3);
        bus.req_data[3] = 64'h3333;
        bus.req_data[0] = 64'h0000_0C0C;
        bus.req_vld     = 4'b1001;
        tick();
        tick();
        bus.req_vld = '0;
        tick();
        tick();
        check_eq("t4_pops", src_log.size(), 3);
        if (src_log.size() == 3) begin
            check_eq("t4_first", src_log[1], 3);
            check_eq("t4_wrap", src_log[2], 0);
        end

        // A retired CPU neither gets ready nor stalls the others.
        do_reset();
        clear_logs();
        bus.req_vld = 4'b0001;
        repeat (3) tick();
        check_eq("t5_cpu0_done", bus.cpu_done, 4'b0001);
        bus.req_vld = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            check_eq("t5_rdy0", bus.req_rdy[0], 0);
            tick();
        end
        bus.req_vld = '0;
        tick();
        tick();
        check_eq("t5_pops", src_log.size(), 6);
        for (int c = 3; c < src_log.size(); c++) check_eq("t5_only_cpu1", src_log[c], 1);
        check_eq("t5_cpu_done", bus.cpu_done, 4'b0011);

        // Reset mid-transfer discards the stage; a grant is allowed right after.
        do_reset();
        bus.out_rdy = 1'b0;
        bus.req_vld = 4'b0010;
        tick();
        check_eq("t6_loaded", bus.out_vld, 1);
        rst = 1'b1;
        #1;
        check_eq("t6_rdy_in_rst", bus.req_rdy, 0);
        tick();
        rst         = 1'b0;
        bus.req_vld = '0;
        check_eq("t6_out_vld", bus.out_vld, 0);
        check_eq("t6_cpu_done", bus.cpu_done, 0);
        check_eq("t6_ptr", dut.rr_ptr_q, 0);
        check_eq("t6_cnt1", dut.cnt_q[1], 0);
        bus.req_vld     = 4'b0010;
        bus.req_data[1] = 64'hBEEF;
        bus.out_rdy     = 1'b1;
        #1;
        check_eq("t6_first_grant", bus.req_rdy, 4'b0010);
        tick();
        check_eq("t6_out_src", bus.out_src, 1);
        check_eq("t6_out_data", bus.out_data, 64'hBEEF);
        bus.req_vld = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 SHALL have parameter CPU_NB, default 4: number of requesting CPU ports, range 2..16.
REQ-002 SHALL have parameter TRANSACTION_NB, default 1000: transactions accepted per CPU before that CPU is retired.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_vld[CPU_NB], input, 1 bit each: CPU i presents data.
REQ-006 SHALL have port req_data[CPU_NB], input, 64 bits each: CPU i payload.
REQ-007 SHALL have port req_rdy[CPU_NB], output, 1 bit each: CPU i payload accepted this cycle when req_vld is also high.
REQ-008 SHALL have port out_vld, output, 1 bit: shared NoC channel holds valid data.
REQ-009 SHALL have port out_data, output, 64 bits: shared channel payload.
REQ-010 SHALL have port out_src, output, $clog2(CPU_NB) bits: index of the originating CPU.
REQ-011 SHALL have port out_rdy, input, 1 bit: NoC accepts out_data this cycle.
REQ-012 SHALL have port cpu_done[CPU_NB], output, 1 bit each: CPU i has completed TRANSACTION_NB accepted transactions.
REQ-013 SHALL have port all_done, output, 1 bit: every CPU is done and the output stage is empty.

Function
REQ-014 SHALL hold one output register stage (out_vld/out_data/out_src); can_accept = !out_vld || out_rdy.
REQ-015 SHALL define eligible[i] = req_vld[i] && !cpu_done[i].
REQ-016 SHALL grant, when can_accept is high, the first eligible index searching upward from rr_ptr with wrap from CPU_NB-1 to 0.
REQ-017 SHALL drive req_rdy one-hot at the granted index, and all-zero when can_accept is low or no index is eligible.
REQ-018 SHALL drive req_rdy combinationally from req_vld, cpu_done, rr_ptr, out_vld and out_rdy; there SHALL be no combinational path from req_data to req_rdy.
REQ-019 SHALL load the granted req_data and its index into the output stage on the accepting edge; latency is exactly 1 cycle from acceptance to out_vld.
REQ-020 SHALL, on a cycle with out_vld && out_rdy and a new grant, replace the output stage with the new data, keeping out_vld high with no bubble.
REQ-021 SHALL clear out_vld when out_vld && out_rdy and no grant occurs.
REQ-022 SHALL hold out_data and out_src stable while out_vld && !out_rdy.
REQ-023 SHALL, after a grant to index g, set rr_ptr to g+1, wrapping from CPU_NB-1 to 0; rr_ptr SHALL be unchanged on cycles without a grant.
REQ-024 SHALL keep a 32-bit accepted-transaction counter per CPU, incremented on each req_vld[i] && req_rdy[i].
REQ-025 SHALL set cpu_done[i] on the edge on which counter i reaches TRANSACTION_NB; cpu_done[i] SHALL stay high until reset, and the counter SHALL stop at TRANSACTION_NB.
REQ-026 SHALL ignore requests from a done CPU: req_rdy stays 0 and the requests do not stall arbitration.
REQ-027 SHALL drive all_done = &cpu_done && !out_vld, registered-free (combinational from state).
REQ-028 SHALL, with a single eligible requester and out_rdy tied high, accept one transaction per cycle (full throughput).

Reset
REQ-029 SHALL, while rst is high at a posedge, set out_vld=0, out_data=0, out_src=0, rr_ptr=0, all counters=0 and all cpu_done=0.
REQ-030 SHALL force req_rdy to all-zero in any cycle where rst is high.
REQ-031 SHALL discard the output stage on a reset asserted mid-transfer, with no replay after reset.
REQ-032 SHALL allow a grant on the first posedge after rst deasserts.

Structure
REQ-033 SHALL take DATA_W=64 and the cpu index typedef (cpu_idx_t) from shared package noc_pkg, which is shared with the noc model.
REQ-034 SHALL place round-robin selection in a combinational sub-module noc_rr_pick (inputs: eligible vector and rr_ptr; outputs: grant_vld and grant_idx); counters and the output stage SHALL live in noc_rr_arbiter.

Verification (CPU_NB=4, TRANSACTION_NB=3 unless stated)
REQ-035 SHALL cover: all four req_vld held high, out_rdy=1 -> out_src sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; then all_done=1.
REQ-036 SHALL cover: only CPU2 valid, data 0xA5A5_0000_0000_0001..3, out_rdy=1 -> three consecutive out_vld cycles carrying the data in order, then cpu_done=0100.
REQ-037 SHALL cover: out_rdy=0 for 5 cycles with CPU1 valid -> exactly one acceptance, out_data stable for 5 cycles, req_rdy[1]=0 meanwhile; when out_rdy rises, the next grant occurs in the same cycle as the pop.
REQ-038 SHALL cover: rr_ptr=3 with CPU3 and CPU0 valid -> CPU3 granted first, then CPU0 (wrap).
REQ-039 SHALL cover: CPU0 done while CPU0 and CPU1 are valid -> only CPU1 is granted, with req_rdy[0]=0 throughout.
REQ-040 SHALL cover: rst pulsed for 1 cycle while out_vld=1 and out_rdy=0 -> next cycle out_vld=0, counters=0, cpu_done=0000 and rr_ptr=0.
